// File: rtl/fifo_pkg.sv
// fifo_pkg: width helpers and parameter legality check shared by the FWFT FIFO blocks.
package fifo_pkg;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit params_ok(input int width, input int depth, input int prog_full, input int prog_empty);
    return width >= 1 && depth >= 2 && (depth & (depth - 1)) == 0 &&
           prog_full >= 1 && prog_full <= depth && prog_empty >= 0 && prog_empty <= depth - 1;
  endfunction
endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: simple dual-port RAM, one write port, one registered read port, array not reset.
module fifo_sync_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fifo_sync_fwft_prog.sv
// fifo_sync_fwft_prog: single-clock FWFT FIFO with level, programmable thresholds, flush and error strobes.
// dout is a head register; the RAM read port prefetches the word behind the head so pops never bubble.
module fifo_sync_fwft_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int PROG_FULL  = DEPTH / 2,
  parameter int PROG_EMPTY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   prog_full,
  output logic                   overflow,
  output logic [WIDTH-1:0]       dout,
  input  logic                   rd_en,
  output logic                   empty,
  output logic                   prog_empty,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  generate
    if (!params_ok(WIDTH, DEPTH, PROG_FULL, PROG_EMPTY)) begin : g_bad_params
      $error("fifo_sync_fwft_prog: illegal WIDTH/DEPTH/PROG_FULL/PROG_EMPTY");
    end
  endgenerate
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt, w_raddr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_dout, r_sdata, w_q, w_sec;
  logic             r_sbyp, r_ovf, r_unf, w_wr, w_rd;
  assign full       = r_level == LW'(DEPTH);
  assign empty      = r_level == '0;
  assign prog_full  = r_level >= LW'(PROG_FULL);
  assign prog_empty = r_level <= LW'(PROG_EMPTY);
  assign overflow   = r_ovf;
  assign underflow  = r_unf;
  assign dout       = r_dout;
  assign level      = r_level;
  assign w_wr         = wr_en && !full && !flush;
  assign w_rd         = rd_en && !empty && !flush;
  assign w_rd_ptr_nxt = flush ? '0 : r_rd_ptr + AW'(w_rd);
  // Read port always targets the slot behind next cycle's head.
  assign w_raddr      = w_rd_ptr_nxt + AW'(1);
  assign w_sec        = r_sbyp ? r_sdata : w_q;
  fifo_sync_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (w_raddr),
    .o_rdata (w_q)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
      r_sdata  <= '0;
      r_sbyp   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wr_ptr <= flush ? '0 : r_wr_ptr + AW'(w_wr);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= flush ? '0 : r_level + LW'(w_wr) - LW'(w_rd);
      r_ovf    <= !flush && wr_en && full;
      r_unf    <= !flush && rd_en && empty;
      // A word written into the prefetch slot is not yet visible on the RAM read port.
      r_sbyp   <= w_wr && (w_raddr == r_wr_ptr);
      r_sdata  <= din;
      if (w_wr && (r_level == '0 || (r_level == LW'(1) && w_rd))) r_dout <= din;
      else if (w_rd && r_level >= LW'(2)) r_dout <= w_sec;
    end
  end
  a_level_max : assert property (@(posedge clk) disable iff (!rst_n) r_level <= LW'(DEPTH));
  a_not_full_empty : assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));
  a_ovf_after_full : assert property (@(posedge clk) disable iff (!rst_n) overflow |-> $past(full));
endmodule

// File: tb/tb_fifo_sync_fwft_prog.sv
// tb_fifo_sync_fwft_prog: directed checks on a DEPTH=4 and a DEPTH=8 instance driven by shared stimulus.
module tb_fifo_sync_fwft_prog;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = '0;
  logic       full4, pfull4, ovf4, empty4, pempty4, unf4;
  logic       full8, pfull8, ovf8, empty8, pempty8, unf8;
  logic [7:0] dout4, dout8;
  logic [2:0] l4;
  logic [3:0] l8;
  int         n_chk = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  fifo_sync_fwft_prog #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .wr_en(wr_en), .full(full4),
    .prog_full(pfull4), .overflow(ovf4), .dout(dout4), .rd_en(rd_en), .empty(empty4),
    .prog_empty(pempty4), .underflow(unf4), .level(l4)
  );
  fifo_sync_fwft_prog #(.WIDTH(8), .DEPTH(8), .PROG_FULL(6), .PROG_EMPTY(2)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .wr_en(wr_en), .full(full8),
    .prog_full(pfull8), .overflow(ovf8), .dout(dout8), .rd_en(rd_en), .empty(empty8),
    .prog_empty(pempty8), .underflow(unf8), .level(l8)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic f, input logic w, input logic r, input logic [7:0] d);
    flush = f;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", l4, 0);
    chk("rst_empty", empty4, 1);
    chk("rst_pempty", pempty4, 1);
    chk("rst_full", full4, 0);
    chk("rst_pfull", pfull4, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_unf", unf4, 0);
    chk("rst_dout", dout4, 0);
    chk("rst_level8", l8, 0);
    rst_n = 1'b1;
    cyc(0, 1, 0, 8'hA1);
    chk("t1_empty", empty4, 0);
    chk("t1_dout", dout4, 8'hA1);
    chk("t1_level", l4, 1);
    cyc(0, 0, 1, 0);
    chk("t1_empty_after_rd", empty4, 1);
    chk("t1_level_after_rd", l4, 0);
    chk("t1_unf", unf4, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 0, 8'(i));
      chk("t2_level", l4, i);
    end
    chk("t2_full", full4, 1);
    chk("t2_pfull", pfull4, 1);
    cyc(0, 1, 0, 8'h05);
    chk("t2_ovf", ovf4, 1);
    chk("t2_level_ovf", l4, 4);
    chk("t2_dout_ovf", dout4, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_dout", dout4, i);
      cyc(0, 0, 1, 0);
      if (i == 1) chk("t2_ovf_pulse", ovf4, 0);
    end
    chk("t2_empty", empty4, 1);
    chk("t2_level0", l4, 0);
    cyc(0, 1, 0, 8'h10);
    cyc(0, 1, 0, 8'h11);
    chk("t3_level_init", l4, 2);
    for (int i = 0; i < 10; i++) begin
      chk("t3_dout", dout4, 8'h10 + i);
      cyc(0, 1, 1, 8'(8'h12 + i));
      chk("t3_level", l4, 2);
      chk("t3_no_err", {ovf4, unf4}, 0);
    end
    chk("t3_drain0", dout4, 8'h1A);
    cyc(0, 0, 1, 0);
    chk("t3_drain1", dout4, 8'h1B);
    cyc(0, 0, 1, 0);
    chk("t3_empty", empty4, 1);
    cyc(0, 1, 1, 8'h55);
    chk("t4_unf", unf4, 1);
    chk("t4_level", l4, 1);
    chk("t4_dout", dout4, 8'h55);
    cyc(0, 0, 0, 0);
    chk("t4_unf_pulse", unf4, 0);
    chk("t4_level_hold", l4, 1);
    cyc(0, 0, 1, 0);
    chk("t4_empty", empty4, 1);
    cyc(1, 0, 0, 0);
    chk("t5_flush_level", l8, 0);
    chk("t5_flush_empty", empty8, 1);
    chk("t5_pempty0", pempty8, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 8'(i));
      chk("t5_fill_level", l8, i);
      chk("t5_fill_pfull", pfull8, i >= 6);
      chk("t5_fill_pempty", pempty8, i <= 2);
    end
    chk("t5_full", full8, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("t5_drain_dout", dout8, i);
      cyc(0, 0, 1, 0);
      chk("t5_drain_level", l8, 8 - i);
      chk("t5_drain_pfull", pfull8, (8 - i) >= 6);
      chk("t5_drain_pempty", pempty8, (8 - i) <= 2);
    end
    chk("t5_empty", empty8, 1);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'(8'h60 + i));
    chk("t6_level5", l8, 5);
    chk("t6_head", dout8, 8'h60);
    chk("t6_u4_full", full4, 1);
    cyc(1, 1, 0, 8'h99);
    chk("t6_flush_level", l8, 0);
    chk("t6_flush_empty", empty8, 1);
    chk("t6_flush_ovf8", ovf8, 0);
    chk("t6_flush_ovf4", ovf4, 0);
    chk("t6_flush_level4", l4, 0);
    chk("t6_flush_dout_hold", dout8, 8'h60);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'(8'h70 + i));
    chk("t6_burst_level", l8, 3);
    wr_en = 1'b1;
    din = 8'h73;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_level", l8, 0);
    chk("t6_arst_empty", empty8, 1);
    chk("t6_arst_dout", dout8, 0);
    chk("t6_arst_pempty", pempty8, 1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("t6_arst_held", l8, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'(8'h80 + i));
    for (int i = 0; i < 27; i++) begin
      chk("t6_wrap_dout8", dout8, 8'h80 + i);
      chk("t6_wrap_dout4", dout4, 8'h80 + i);
      cyc(0, 1, 1, 8'(8'h83 + i));
    end
    for (int i = 27; i < 30; i++) begin
      chk("t6_wrap_drain", dout8, 8'h80 + i);
      cyc(0, 0, 1, 0);
    end
    chk("t6_wrap_empty", empty8, 1);
    chk("t6_wrap_level", l8, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
